// File: rtl/hilo_md_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide scheduler.
// Opcode values and FSM states used by the controller and its divider.
package hilo_md_ctrl_pkg;

  localparam logic [2:0] HILO_OP_MULT  = 3'd0;
  localparam logic [2:0] HILO_OP_MULTU = 3'd1;
  localparam logic [2:0] HILO_OP_DIV   = 3'd2;
  localparam logic [2:0] HILO_OP_DIVU  = 3'd3;
  localparam logic [2:0] HILO_OP_MTHI  = 3'd4;
  localparam logic [2:0] HILO_OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  // Opcodes 6 and 7 are not HI/LO ops and must never stall a slot.
  function automatic logic op_known(input logic [2:0] op);
    return op <= HILO_OP_MTLO;
  endfunction

endpackage

// File: rtl/hilo_md_ctrl_div_iter.sv
// Radix-2 restoring unsigned divider, one quotient bit per cycle.
// The first step runs in the start cycle so done rises DIV_BITS cycles later.
module hilo_md_ctrl_div_iter #(
  parameter int DIV_BITS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [DIV_BITS-1:0] dividend,
  input  logic [DIV_BITS-1:0] divisor,
  output logic [DIV_BITS-1:0] quotient,
  output logic [DIV_BITS-1:0] remainder,
  output logic                done
);

  localparam int CW = $clog2(DIV_BITS + 1);

  logic [DIV_BITS-1:0] rem_q, rem_d;
  logic [DIV_BITS-1:0] quo_q, quo_d;
  logic [DIV_BITS-1:0] dvs_q, dvs_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                done_q, done_d;

  logic [DIV_BITS-1:0] src_rem;
  logic [DIV_BITS-1:0] src_quo;
  logic [DIV_BITS-1:0] src_dvs;
  logic [DIV_BITS:0]   shl;
  logic [DIV_BITS:0]   diff;

  always_comb begin
    src_rem = start ? '0 : rem_q;
    src_quo = start ? dividend : quo_q;
    src_dvs = start ? divisor : dvs_q;
    shl     = {src_rem, src_quo[DIV_BITS-1]};
    diff    = shl - {1'b0, src_dvs};
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (abort) begin
      cnt_d = '0;
    end else if (start || cnt_q != '0) begin
      dvs_d = src_dvs;
      // A borrow out of the trial subtract means the divisor did not fit.
      if (!diff[DIV_BITS]) begin
        rem_d = diff[DIV_BITS-1:0];
        quo_d = {src_quo[DIV_BITS-2:0], 1'b1};
      end else begin
        rem_d = shl[DIV_BITS-1:0];
        quo_d = {src_quo[DIV_BITS-2:0], 1'b0};
      end
      cnt_d  = start ? CW'(DIV_BITS - 1) : cnt_q - 1'b1;
      done_d = (cnt_d == '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = done_q;

endmodule

// File: rtl/hilo_md_ctrl.sv
// HI/LO multiply/divide scheduler for the dual-issue core.
// Accepts one op per cycle from two slots and sequences MUL/DIV writes.
module hilo_md_ctrl
  import hilo_md_ctrl_pkg::*;
#(
  parameter int MUL_LAT  = 2,
  parameter int DIV_BITS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                op1_valid,
  input  logic [2:0]          op1,
  input  logic [DIV_BITS-1:0] op1_a,
  input  logic [DIV_BITS-1:0] op1_b,
  input  logic                op2_valid,
  input  logic [2:0]          op2,
  input  logic [DIV_BITS-1:0] op2_a,
  input  logic [DIV_BITS-1:0] op2_b,
  input  logic                flush,
  output logic                stall1,
  output logic                stall2,
  output logic                busy,
  output logic                hi_w_en,
  output logic [DIV_BITS-1:0] hi_w_data,
  output logic                lo_w_en,
  output logic [DIV_BITS-1:0] lo_w_data
);

  localparam int W  = DIV_BITS;
  localparam int MW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  md_state_e     state_q, state_d;
  logic [MW-1:0] cnt_q, cnt_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic          hi_en_q, hi_en_d;
  logic          lo_en_q, lo_en_d;
  logic [W-1:0]  hi_dat_q, hi_dat_d;
  logic [W-1:0]  lo_dat_q, lo_dat_d;

  logic          v1, v2, acc1, acc2, acc;
  logic [2:0]    sel_op;
  logic [W-1:0]  sel_a, sel_b, a_mag, b_mag;
  logic          sgn, a_neg, b_neg;
  logic          is_mul, div_z, div_nz, op_mthi, op_mtlo;
  logic [2*W-1:0] ext_a, ext_b, prod;
  logic          div_start, div_done;
  logic [W-1:0]  div_quo, div_rem;

  assign busy   = (state_q != ST_IDLE);
  assign v1     = op1_valid && op_known(op1);
  assign v2     = op2_valid && op_known(op2);
  assign stall1 = v1 && busy;
  assign stall2 = v2 && (busy || v1);
  assign acc1   = v1 && !busy && !flush;
  assign acc2   = v2 && !v1 && !busy && !flush;
  assign acc    = acc1 || acc2;

  always_comb begin
    sel_op  = acc1 ? op1   : op2;
    sel_a   = acc1 ? op1_a : op2_a;
    sel_b   = acc1 ? op1_b : op2_b;
    sgn     = (sel_op == HILO_OP_MULT) || (sel_op == HILO_OP_DIV);
    a_neg   = sgn && sel_a[W-1];
    b_neg   = sgn && sel_b[W-1];
    a_mag   = a_neg ? -sel_a : sel_a;
    b_mag   = b_neg ? -sel_b : sel_b;
    ext_a   = {{W{a_neg}}, sel_a};
    ext_b   = {{W{b_neg}}, sel_b};
    prod    = ext_a * ext_b;
    is_mul  = (sel_op == HILO_OP_MULT) || (sel_op == HILO_OP_MULTU);
    div_z   = (sel_op == HILO_OP_DIV || sel_op == HILO_OP_DIVU)
              && (sel_b == '0);
    div_nz  = (sel_op == HILO_OP_DIV || sel_op == HILO_OP_DIVU)
              && (sel_b != '0);
    op_mthi = (sel_op == HILO_OP_MTHI);
    op_mtlo = (sel_op == HILO_OP_MTLO);
  end

  assign div_start = acc && div_nz && (state_q == ST_IDLE);

  hilo_md_ctrl_div_iter #(
    .DIV_BITS (DIV_BITS)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .abort     (flush),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    hi_en_d  = 1'b0;
    lo_en_d  = 1'b0;
    hi_dat_d = hi_dat_q;
    lo_dat_d = lo_dat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (acc) begin
          unique case (1'b1)
            is_mul: begin
              state_d = ST_MUL;
              cnt_d   = MW'(MUL_LAT - 1);
              prod_d  = prod;
            end
            div_z: begin
              hi_en_d  = 1'b1;
              lo_en_d  = 1'b1;
              hi_dat_d = sel_a;
              lo_dat_d = '1;
            end
            div_nz: begin
              state_d = ST_DIV;
              qneg_d  = a_neg ^ b_neg;
              rneg_d  = a_neg;
            end
            op_mthi: begin
              hi_en_d  = 1'b1;
              hi_dat_d = sel_a;
            end
            op_mtlo: begin
              lo_en_d  = 1'b1;
              lo_dat_d = sel_a;
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d  = ST_IDLE;
          hi_en_d  = 1'b1;
          lo_en_d  = 1'b1;
          hi_dat_d = prod_q[2*W-1:W];
          lo_dat_d = prod_q[W-1:0];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DIV: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (div_done) begin
          state_d  = ST_IDLE;
          hi_en_d  = 1'b1;
          lo_en_d  = 1'b1;
          hi_dat_d = rneg_q ? -div_rem : div_rem;
          lo_dat_d = qneg_q ? -div_quo : div_quo;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      hi_en_q  <= 1'b0;
      lo_en_q  <= 1'b0;
      hi_dat_q <= '0;
      lo_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      hi_en_q  <= hi_en_d;
      lo_en_q  <= lo_en_d;
      hi_dat_q <= hi_dat_d;
      lo_dat_q <= lo_dat_d;
    end
  end

  assign hi_w_en   = hi_en_q;
  assign lo_w_en   = lo_en_q;
  assign hi_w_data = hi_dat_q;
  assign lo_w_data = lo_dat_q;

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Self-checking bench for hilo_md_ctrl: directed cases plus random ops
// compared against an arithmetic reference model.
module tb_hilo_md_ctrl;

  localparam int MUL_LAT = 2;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op1_valid = 1'b0;
  logic [2:0]  op1 = '0;
  logic [31:0] op1_a = '0, op1_b = '0;
  logic        op2_valid = 1'b0;
  logic [2:0]  op2 = '0;
  logic [31:0] op2_a = '0, op2_b = '0;
  logic        flush = 1'b0;
  logic        stall1, stall2, busy;
  logic        hi_w_en, lo_w_en;
  logic [31:0] hi_w_data, lo_w_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hilo_md_ctrl #(.MUL_LAT(MUL_LAT), .DIV_BITS(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .op1_valid (op1_valid),
    .op1       (op1),
    .op1_a     (op1_a),
    .op1_b     (op1_b),
    .op2_valid (op2_valid),
    .op2       (op2),
    .op2_a     (op2_a),
    .op2_b     (op2_b),
    .flush     (flush),
    .stall1    (stall1),
    .stall2    (stall2),
    .busy      (busy),
    .hi_w_en   (hi_w_en),
    .hi_w_data (hi_w_data),
    .lo_w_en   (lo_w_en),
    .lo_w_data (lo_w_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: expected strobes {hi,lo}, values, strobe latency and busy cycles.
  task automatic model(input logic [2:0] op, input logic [31:0] a, b,
                       output logic [1:0] en, output logic [31:0] hi, lo,
                       output int lat, output int bsy);
    logic [63:0] p;
    longint sa, sb, q, r;
    en = 2'b00; hi = '0; lo = '0; lat = -1; bsy = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT: begin
        p = 64'(sa * sb);
        en = 2'b11; hi = p[63:32]; lo = p[31:0];
        lat = MUL_LAT; bsy = MUL_LAT;
      end
      OP_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        en = 2'b11; hi = p[63:32]; lo = p[31:0];
        lat = MUL_LAT; bsy = MUL_LAT;
      end
      OP_DIV, OP_DIVU: begin
        en = 2'b11;
        if (b == 0) begin
          hi = a; lo = 32'hFFFF_FFFF; lat = 0; bsy = 0;
        end else begin
          lat = 32; bsy = 32;
          if (op == OP_DIV) begin
            q = sa / sb; r = sa % sb;
            lo = q[31:0]; hi = r[31:0];
          end else begin
            lo = a / b; hi = a % b;
          end
        end
      end
      OP_MTHI: begin en = 2'b10; hi = a; lat = 0; end
      OP_MTLO: begin en = 2'b01; lo = a; lat = 0; end
      default: ;
    endcase
  endtask

  task automatic do_op(input int slot, input logic [2:0] op,
                       input logic [31:0] a, b, input string tag);
    logic [1:0]  een;
    logic [31:0] eh, el;
    int          elat, ebsy;
    int          first = -1;
    int          nstb = 0;
    int          nbsy = 0;
    logic [1:0]  sen = 2'b00;
    logic [31:0] sh = '0, sl = '0;
    model(op, a, b, een, eh, el, elat, ebsy);
    @(negedge clk);
    if (slot == 1) begin
      op1_valid = 1'b1; op1 = op; op1_a = a; op1_b = b;
    end else begin
      op2_valid = 1'b1; op2 = op; op2_a = a; op2_b = b;
    end
    #1 chk({tag, " idle_stall"}, {stall1, stall2}, 2'b00);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (busy) nbsy++;
      if (hi_w_en || lo_w_en) begin
        nstb++;
        if (first < 0) begin
          first = n; sen = {hi_w_en, lo_w_en};
          sh = hi_w_data; sl = lo_w_data;
        end
      end
      op1_valid = 1'b0;
      op2_valid = 1'b0;
    end
    chk({tag, " latency"}, first, elat);
    chk({tag, " strobe_cycles"}, nstb, (elat >= 0) ? 1 : 0);
    chk({tag, " strobe_en"}, sen, een);
    chk({tag, " busy_cycles"}, nbsy, ebsy);
    if (een[1]) chk({tag, " hi"}, sh, eh);
    if (een[0]) chk({tag, " lo"}, sl, el);
  endtask

  initial begin
    int nstb;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_en", {hi_w_en, lo_w_en}, 2'b00);
    chk("reset_data", {hi_w_data, lo_w_data}, 64'd0);
    chk("reset_stall", {stall1, stall2}, 2'b00);
    reset = 1'b1;

    do_op(1, OP_MULTU, 32'hFFFF_FFFF, 32'd2, "multu_max_x2");
    do_op(1, OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    do_op(2, OP_DIVU, 32'h1357_9BDF, 32'd0, "divu_by0");
    do_op(2, OP_MULT, 32'h8000_0000, 32'hFFFF_FFFF, "mult_min_m1");
    do_op(1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");

    // MTHI in slot 1 and MTLO in slot 2 together
    @(negedge clk);
    op1_valid = 1'b1; op1 = OP_MTHI; op1_a = 32'h1234;
    op2_valid = 1'b1; op2 = OP_MTLO; op2_a = 32'h5678;
    #1 chk("mt_pair stall", {stall1, stall2}, 2'b01);
    @(negedge clk);
    chk("mt_pair hi_first", {hi_w_en, lo_w_en, hi_w_data}, {2'b10, 32'h1234});
    op1_valid = 1'b0;
    #1 chk("mt_pair stall_clear", stall2, 1'b0);
    @(negedge clk);
    chk("mt_pair lo_second", {hi_w_en, lo_w_en, lo_w_data}, {2'b01, 32'h5678});
    op2_valid = 1'b0;
    @(negedge clk);
    chk("mt_pair quiet", {hi_w_en, lo_w_en}, 2'b00);

    // Ignored opcode in slot 1 lets slot 2 through
    @(negedge clk);
    op1_valid = 1'b1; op1 = 3'd7;
    op2_valid = 1'b1; op2 = OP_MTHI; op2_a = 32'hABCD;
    #1 chk("op7_no_stall", {stall1, stall2}, 2'b00);
    @(negedge clk);
    op1_valid = 1'b0; op2_valid = 1'b0;
    chk("op7_slot2_taken", {hi_w_en, lo_w_en, hi_w_data}, {2'b10, 32'hABCD});

    // DIV, stalls while busy, flush at cycle 10
    @(negedge clk);
    op1_valid = 1'b1; op1 = OP_DIV; op1_a = 32'hFFFF_FF9C; op1_b = 32'd7;
    @(negedge clk);
    op1_valid = 1'b0;
    chk("flush busy_up", busy, 1'b1);
    repeat (2) @(negedge clk);
    op1_valid = 1'b1; op1 = OP_MTHI;
    #1 chk("busy stall1", stall1, 1'b1);
    op1 = 3'd6;
    #1 chk("busy op6_no_stall", stall1, 1'b0);
    op2_valid = 1'b1; op2 = OP_MTLO;
    #1 chk("busy stall2", stall2, 1'b1);
    op1_valid = 1'b0; op2_valid = 1'b0;
    repeat (7) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy_down", busy, 1'b0);
    nstb = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (hi_w_en || lo_w_en) nstb++;
    end
    chk("flush no_strobe", nstb, 0);
    do_op(1, OP_MULT, 32'hFFFF_FFFD, 32'd5, "mult_after_flush");

    // Flush in IDLE drops the op
    @(negedge clk);
    op1_valid = 1'b1; op1 = OP_MTHI; op1_a = 32'hDEAD; flush = 1'b1;
    @(negedge clk);
    op1_valid = 1'b0; flush = 1'b0;
    chk("idle_flush drop", {hi_w_en, lo_w_en}, 2'b00);

    // Reset in the middle of a DIV
    @(negedge clk);
    op1_valid = 1'b1; op1 = OP_DIVU; op1_a = 32'd100; op1_b = 32'd3;
    @(negedge clk);
    op1_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1 chk("midreset outputs",
           {busy, hi_w_en, lo_w_en, hi_w_data, lo_w_data}, 67'd0);
    @(negedge clk);
    reset = 1'b1;
    do_op(2, OP_MULTU, 32'h0001_0000, 32'h0001_0003, "multu_after_reset");

    for (int i = 0; i < 36; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 31);
      do_op($urandom_range(1, 2), rop, ra, rb, $sformatf("rand%0d_op%0d", i, rop));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
